// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - game turn controller: button debounce, turn FSM, winner latch
//
// Owns the 2-bit current-player index T consumed by the player-select decoder.
// A debounced start/restart button walks the game IDLE -> PLAY -> OVER -> IDLE;
// misses from the tile-compare stage advance T modulo PLAYERS, and a win
// freezes T and latches the winner.
//
// Parameters:
//   PLAYERS          number of active players (2..4); T wraps modulo PLAYERS
//   DEBOUNCE_CYCLES  consecutive stable cycles before a button level is accepted (>= 2)
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   btn_in        in   raw push-button level, asynchronous to clk
//   result_valid  in   one-cycle pulse: a guess has been resolved
//   result_hit    in   qualifies result_valid: 1 = hit, 0 = miss
//   win_in        in   one-cycle pulse: current player has won
//   T             out  current player index (registered)
//   turn_change   out  one-cycle pulse in the first cycle a new T / new game is valid
//   playing       out  high while in PLAY
//   game_over     out  high while in OVER
//   winner        out  player index latched at the win; valid while game_over

module turn_sequencer #(
  parameter int PLAYERS         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       result_valid,
  input  logic       result_hit,
  input  logic       win_in,
  output logic [1:0] T,
  output logic       turn_change,
  output logic       playing,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]     T_LAST   = 2'(PLAYERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchroniser, then a stability counter.
  // ---------------------------------------------------------------------------
  logic [1:0]    sync_q;
  logic          btn_s;
  logic          btn_deb_q, btn_deb_d;
  logic          btn_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press;

  assign btn_s = sync_q[1];

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) restarts the count. Accepting
  // on CNT_LAST means the new level must have been seen on DEBOUNCE_CYCLES
  // consecutive edges.
  always_comb begin
    cnt_d     = '0;
    btn_deb_d = btn_deb_q;
    if (btn_s != btn_deb_q) begin
      if (cnt_q == CNT_LAST) begin
        btn_deb_d = btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Rising edge of the accepted level only; releases are silent.
  assign press = btn_deb_q & ~btn_prev_q;

  // ---------------------------------------------------------------------------
  // Turn state machine.
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] t_q, t_d;
  logic [1:0] winner_q, winner_d;
  logic       turn_change_q, turn_change_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    winner_d      = winner_q;
    turn_change_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        t_d = 2'd0;
        if (press) begin
          state_d       = S_PLAY;
          turn_change_d = 1'b1;
        end
      end

      S_PLAY: begin
        // A win ends the game even if a result arrives in the same cycle.
        if (win_in) begin
          state_d  = S_OVER;
          winner_d = t_q;
        end else if (result_valid && !result_hit) begin
          t_d           = (t_q == T_LAST) ? 2'd0 : t_q + 2'd1;
          turn_change_d = 1'b1;
        end
      end

      S_OVER: begin
        if (press) begin
          state_d  = S_IDLE;
          t_d      = 2'd0;
          winner_d = 2'd0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        t_d      = 2'd0;
        winner_d = 2'd0;
      end
    endcase

    // Status flags are registered from the next state so they line up with T.
    playing_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // ---------------------------------------------------------------------------
  // Registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 2'b00;
      btn_deb_q     <= 1'b0;
      btn_prev_q    <= 1'b0;
      cnt_q         <= '0;
      state_q       <= S_IDLE;
      t_q           <= 2'd0;
      winner_q      <= 2'd0;
      turn_change_q <= 1'b0;
      playing_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], btn_in};
      btn_deb_q     <= btn_deb_d;
      btn_prev_q    <= btn_deb_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      t_q           <= t_d;
      winner_q      <= winner_d;
      turn_change_q <= turn_change_d;
      playing_q     <= playing_d;
      game_over_q   <= game_over_d;
    end
  end

  assign T           = t_q;
  assign winner      = winner_q;
  assign turn_change = turn_change_q;
  assign playing     = playing_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - randomized self-checking bench for turn_sequencer (4- and 3-player instances)

module tb_turn_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, btn_in, result_valid, result_hit, win_in;
  logic [1:0] t4, w4, t3, w3;
  logic       tc4, pl4, go4, tc3, pl3, go3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_sequencer #(.PLAYERS(4), .DEBOUNCE_CYCLES(D)) dut4 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .result_valid(result_valid),
    .result_hit(result_hit), .win_in(win_in), .T(t4), .turn_change(tc4),
    .playing(pl4), .game_over(go4), .winner(w4)
  );

  turn_sequencer #(.PLAYERS(3), .DEBOUNCE_CYCLES(D)) dut3 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .result_valid(result_valid),
    .result_hit(result_hit), .win_in(win_in), .T(t3), .turn_change(tc3),
    .playing(pl3), .game_over(go3), .winner(w3)
  );

  // Reference model. Button: history of sampled levels, accepted level, run
  // length of disagreement, and a pending press seen by the game on the next edge.
  // Game: mode 0=idle 1=play 2=over, per instance k (0: 4 players, 1: 3 players).
  int s1, s2, deb, run, pp;
  int m_mode[2], m_t[2], m_win[2], m_tc[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      s1 = 0; s2 = 0; deb = 0; run = 0; pp = 0;
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_t[k] = 0; m_win[k] = 0; m_tc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int np;
        np = (k == 0) ? 4 : 3;
        m_tc[k] = 0;
        if (m_mode[k] == 0) begin
          if (pp != 0) begin m_mode[k] = 1; m_tc[k] = 1; end
        end else if (m_mode[k] == 1) begin
          if (win_in) begin
            m_mode[k] = 2; m_win[k] = m_t[k];
          end else if (result_valid && !result_hit) begin
            m_t[k] = (m_t[k] + 1) % np; m_tc[k] = 1;
          end
        end else begin
          if (pp != 0) begin m_mode[k] = 0; m_t[k] = 0; m_win[k] = 0; end
        end
      end
      pp = 0;
      if (s2 != deb) begin
        run++;
        if (run == D) begin deb = s2; run = 0; pp = s2; end
      end else begin
        run = 0;
      end
      s2 = s1;
      s1 = int'(btn_in);
    end
  endtask

  task automatic compare();
    check("T4",        t4,  m_t[0]);
    check("tc4",       tc4, m_tc[0]);
    check("playing4",  pl4, m_mode[0] == 1);
    check("over4",     go4, m_mode[0] == 2);
    check("winner4",   w4,  m_win[0]);
    check("T3",        t3,  m_t[1]);
    check("tc3",       tc3, m_tc[1]);
    check("playing3",  pl3, m_mode[1] == 1);
    check("over3",     go3, m_mode[1] == 2);
    check("winner3",   w3,  m_win[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic hold_btn(input logic lvl, input int n);
    btn_in = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic miss_once();
    result_valid = 1'b1; result_hit = 1'b0;
    tick();
    result_valid = 1'b0;
  endtask

  int e4[5] = '{1, 2, 3, 0, 1};
  int e3[5] = '{1, 2, 0, 1, 2};
  int first_tc, n_tc, hold;
  int bounce[4] = '{1, 0, 1, 0};

  initial begin
    rst = 1'b1; btn_in = 1'b0; result_valid = 1'b0; result_hit = 1'b0; win_in = 1'b0;
    repeat (3) tick();
    check("reset_T",      t4, 0);
    check("reset_play",   pl4, 0);
    rst = 1'b0;
    tick();

    // Bounce shorter than the debounce period never starts a game.
    for (int j = 0; j < 4; j++) hold_btn(bounce[j][0], 3);
    hold_btn(1'b0, 4);
    check("bounce_idle", pl4, 0);

    // Clean press: turn_change on the 7th sampled edge counting the first high sample as edge 1.
    btn_in = 1'b1; first_tc = -1; n_tc = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (tc4) begin n_tc++; if (first_tc < 0) first_tc = i; end
    end
    check("start_latency", first_tc, 2 + D + 1);
    check("start_pulses",  n_tc, 1);
    check("start_T",       t4, 0);

    // Five back-to-back misses.
    result_valid = 1'b1; result_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("miss_seq4", t4, e4[i]);
      check("miss_seq3", t3, e3[i]);
      check("miss_tc4",  tc4, 1);
    end
    result_valid = 1'b0;
    tick();
    check("miss_tc_end", tc4, 0);

    // Hit at T=2 holds the turn.
    miss_once();
    result_valid = 1'b1; result_hit = 1'b1;
    tick();
    result_valid = 1'b0;
    check("hit_T",  t4, 2);
    check("hit_tc", tc4, 0);

    // Win beats a simultaneous miss at T=3.
    miss_once();
    win_in = 1'b1; result_valid = 1'b1; result_hit = 1'b0;
    tick();
    win_in = 1'b0; result_valid = 1'b0;
    check("win_over",   go4, 1);
    check("win_winner", w4, 3);
    check("win_T",      t4, 3);
    check("win_tc",     tc4, 0);
    check("win_play",   pl4, 0);

    // Release then press: back to IDLE with cleared T/winner.
    hold_btn(1'b0, 8);
    hold_btn(1'b1, 8);
    check("restart_over", go4, 0);
    check("restart_T",    t4, 0);
    check("restart_win",  w4, 0);
    hold_btn(1'b0, 8);
    hold_btn(1'b1, 8);

    // Randomized traffic against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_in = ($urandom_range(0, 1) == 1);
        hold   = $urandom_range(1, 10);
      end
      hold--;
      result_valid = ($urandom_range(0, 2) == 0);
      result_hit   = ($urandom_range(0, 1) == 1);
      win_in       = ($urandom_range(0, 40) == 0);
      rst          = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0; result_valid = 1'b0; win_in = 1'b0;

    // Reset mid-game at T=2 with a half-counted release.
    rst = 1'b1; tick(); rst = 1'b0;
    hold_btn(1'b0, 2);
    hold_btn(1'b1, 8);
    miss_once();
    miss_once();
    check("mid_T_pre", t4, 2);
    hold_btn(1'b0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_T",    t4, 0);
    check("mid_rst_play", pl4, 0);
    check("mid_rst_tc",   tc4, 0);
    btn_in = 1'b1; first_tc = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (tc4 && first_tc < 0) first_tc = i;
    end
    check("mid_restart_latency", first_tc, 2 + D + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
